// File: rtl/pipe_ctrl_pkg.sv
// Shared types and defaults for the ToyMIPS pipeline sequencer.
package pipe_ctrl_pkg;

  localparam int unsigned PC_CNT_W_DEF     = 32;
  localparam int unsigned PC_DRAIN_CYC_DEF = 4;

  typedef enum logic [1:0] {
    PC_RUN   = 2'b00,
    PC_MWAIT = 2'b01,
    PC_DRAIN = 2'b10,
    PC_HALT  = 2'b11
  } pc_state_e;

  // Per-stage control bundle: enables, flushes and MEM/WB bubble
  typedef struct packed {
    logic pc_en;
    logic if_id_en;
    logic id_ex_en;
    logic ex_mem_en;
    logic mem_wb_en;
    logic if_id_flush;
    logic id_ex_flush;
    logic mem_wb_bubble;
  } pipe_ctl_t;

  localparam pipe_ctl_t CTL_RUN    = pipe_ctl_t'(8'b11111_000);
  localparam pipe_ctl_t CTL_MWAIT  = pipe_ctl_t'(8'b00001_001);
  localparam pipe_ctl_t CTL_BRANCH = pipe_ctl_t'(8'b11111_110);
  localparam pipe_ctl_t CTL_LDUSE  = pipe_ctl_t'(8'b00111_010);
  localparam pipe_ctl_t CTL_HALT   = pipe_ctl_t'(8'b00000_000);

endpackage

// File: rtl/pipe_ctrl_if.sv
// Hazard/handshake inputs and stage-control outputs of the pipeline sequencer.
interface pipe_ctrl_if #(parameter int unsigned CNT_W = 32);
  logic             ld_use_stall;
  logic             br_taken;
  logic             dmem_req;
  logic             dmem_ack;
  logic             halt_req;
  logic             resume;
  logic             wb_valid;
  logic             cnt_clr;
  logic             pc_en;
  logic             if_id_en;
  logic             id_ex_en;
  logic             ex_mem_en;
  logic             mem_wb_en;
  logic             if_id_flush;
  logic             id_ex_flush;
  logic             mem_wb_bubble;
  logic             halted;
  logic [1:0]       state;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] retire_cnt;

  modport master (
    output ld_use_stall, br_taken, dmem_req, dmem_ack, halt_req, resume, wb_valid, cnt_clr,
    input  pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en, if_id_flush, id_ex_flush,
    input  mem_wb_bubble, halted, state, stall_cnt, retire_cnt
  );

  modport slave (
    input  ld_use_stall, br_taken, dmem_req, dmem_ack, halt_req, resume, wb_valid, cnt_clr,
    output pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en, if_id_flush, id_ex_flush,
    output mem_wb_bubble, halted, state, stall_cnt, retire_cnt
  );
endinterface

// File: rtl/pipe_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear that wins over increment.
module sat_counter #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (inc && (q != {W{1'b1}})) begin
      q <= q + W'(1);
    end
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline sequencer: hazard-to-enable mapping, debug halt/drain FSM, perf counters.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W     = PC_CNT_W_DEF,
  parameter int unsigned DRAIN_CYC = PC_DRAIN_CYC_DEF
) (
  input logic       clk,
  input logic       rst_n,
  pipe_ctrl_if.slave bus
);

  localparam int unsigned DW = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;

  pc_state_e     state_q, state_d;
  logic [DW-1:0] drain_q, drain_d;
  logic          pend_q, pend_d;
  logic          mwait;
  pipe_ctl_t     ctl;

  assign mwait = (state_q != PC_HALT) && bus.dmem_req && !bus.dmem_ack;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= PC_RUN;
      drain_q <= '0;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      drain_q <= drain_d;
      pend_q  <= pend_d;
    end
  end

  // Priority: memory wait > branch flush > load-use > normal
  always_comb begin
    state_d = state_q;
    drain_d = drain_q;
    pend_d  = pend_q;
    ctl     = CTL_RUN;
    unique case (state_q)
      PC_RUN, PC_MWAIT: begin
        pend_d = pend_q | bus.halt_req;
        if (mwait) begin
          ctl     = CTL_MWAIT;
          state_d = PC_MWAIT;
        end else begin
          if (bus.br_taken)          ctl = CTL_BRANCH;
          else if (bus.ld_use_stall) ctl = CTL_LDUSE;
          if (pend_d) begin
            state_d = PC_DRAIN;
            drain_d = DW'(DRAIN_CYC - 1);
          end else begin
            state_d = PC_RUN;
          end
        end
      end
      PC_DRAIN: begin
        if (mwait) begin
          ctl = CTL_MWAIT;
        end else if (bus.ld_use_stall && !bus.br_taken) begin
          // Hold the ID instruction; only unstalled cycles advance the drain
          ctl = CTL_LDUSE;
        end else begin
          ctl             = CTL_RUN;
          ctl.pc_en       = 1'b0;
          ctl.if_id_flush = 1'b1;
          ctl.id_ex_flush = bus.br_taken;
          if (drain_q == '0) state_d = PC_HALT;
          else               drain_d = drain_q - DW'(1);
        end
      end
      PC_HALT: begin
        ctl = CTL_HALT;
        if (bus.resume) begin
          state_d = PC_RUN;
          pend_d  = 1'b0;
        end
      end
    endcase
  end

  // Reset forces all stages closed and NOPs loaded, independent of the clock
  assign bus.pc_en         = rst_n & ctl.pc_en;
  assign bus.if_id_en      = rst_n & ctl.if_id_en;
  assign bus.id_ex_en      = rst_n & ctl.id_ex_en;
  assign bus.ex_mem_en     = rst_n & ctl.ex_mem_en;
  assign bus.mem_wb_en     = rst_n & ctl.mem_wb_en;
  assign bus.if_id_flush   = !rst_n | ctl.if_id_flush;
  assign bus.id_ex_flush   = !rst_n | ctl.id_ex_flush;
  assign bus.mem_wb_bubble = !rst_n | ctl.mem_wb_bubble;
  assign bus.halted        = rst_n & (state_q == PC_HALT);
  assign bus.state         = state_q;

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (!ctl.pc_en && (state_q != PC_HALT)),
    .clr   (bus.cnt_clr),
    .q     (bus.stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_retire_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (bus.wb_valid),
    .clr   (bus.cnt_clr),
    .q     (bus.retire_cnt)
  );

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: directed table, multi-cycle sequences, random vs model.
module tb_pipe_ctrl;

  localparam int unsigned CNT_W     = 4;
  localparam int unsigned DRAIN_CYC = 4;
  localparam int          CMAX      = (1 << CNT_W) - 1;

  typedef struct packed {
    logic ld, br, req, ack, hreq, res, wbv, clr;
  } in_t;

  typedef struct packed {
    logic pc, ifid, idex, exmem, memwb, ifid_fl, idex_fl, bub, halted;
    logic [1:0] st;
  } out_t;

  typedef struct {
    in_t   i;
    out_t  o;
    string name;
  } vec_t;

  localparam in_t I_0       = 8'b0000_0000;
  localparam in_t I_LD      = 8'b1000_0000;
  localparam in_t I_BR      = 8'b0100_0000;
  localparam in_t I_BRLD    = 8'b1100_0000;
  localparam in_t I_REQ     = 8'b0010_0000;
  localparam in_t I_REQBR   = 8'b0110_0000;
  localparam in_t I_REQACK  = 8'b0011_0000;
  localparam in_t I_REQACKL = 8'b1011_0000;
  localparam in_t I_HREQ    = 8'b0000_1000;
  localparam in_t I_HRES    = 8'b0000_1100;
  localparam in_t I_RES     = 8'b0000_0100;
  localparam in_t I_BRLDH   = 8'b1100_1000;
  localparam in_t I_WB      = 8'b0000_0010;
  localparam in_t I_CLR     = 8'b0000_0001;
  localparam in_t I_CLRLD   = 8'b1000_0001;

  // Output patterns without state field (state added by with_st)
  localparam out_t O_RUN  = 11'b11111_000_0_00;
  localparam out_t O_LDU  = 11'b00111_010_0_00;
  localparam out_t O_BR   = 11'b11111_110_0_00;
  localparam out_t O_MW   = 11'b00001_001_0_00;
  localparam out_t O_DRN  = 11'b01111_100_0_00;
  localparam out_t O_DBR  = 11'b01111_110_0_00;
  localparam out_t O_HALT = 11'b00000_000_1_00;
  localparam out_t O_RST  = 11'b00000_111_0_00;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  pipe_ctrl_if #(.CNT_W(CNT_W)) bus ();

  pipe_ctrl #(.CNT_W(CNT_W), .DRAIN_CYC(DRAIN_CYC)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int   vectors;
  int   miscompares;
  out_t last;

  // Reference model: mode 0=running 1=mem-waiting 2=draining 3=halted
  int m_mode;
  int m_left;
  bit m_pend;
  int m_stall;
  int m_retire;

  function automatic out_t with_st(input out_t o, input logic [1:0] s);
    out_t r = o;
    r.st = s;
    return r;
  endfunction

  function automatic out_t m_out(input in_t i);
    out_t o;
    bit   waiting = (m_mode != 3) && i.req && !i.ack;
    if (m_mode == 3)                o = O_HALT;
    else if (waiting)               o = O_MW;
    else if (m_mode == 2) begin
      if (i.ld && !i.br)            o = O_LDU;
      else if (i.br)                o = O_DBR;
      else                          o = O_DRN;
    end
    else if (i.br)                  o = O_BR;
    else if (i.ld)                  o = O_LDU;
    else                            o = O_RUN;
    o.st = 2'(m_mode);
    return o;
  endfunction

  task automatic m_reset();
    m_mode = 0; m_left = 0; m_pend = 0; m_stall = 0; m_retire = 0;
  endtask

  task automatic m_step(input in_t i);
    out_t o       = m_out(i);
    bit   waiting = (m_mode != 3) && i.req && !i.ack;
    if (i.clr) begin
      m_stall = 0; m_retire = 0;
    end else begin
      if (!o.pc && m_mode != 3 && m_stall < CMAX) m_stall++;
      if (i.wbv && m_retire < CMAX) m_retire++;
    end
    case (m_mode)
      0, 1: begin
        m_pend = m_pend | i.hreq;
        if (waiting)     m_mode = 1;
        else if (m_pend) begin m_mode = 2; m_left = DRAIN_CYC; end
        else             m_mode = 0;
      end
      2: begin
        if (!(waiting || (i.ld && !i.br))) begin
          m_left--;
          if (m_left == 0) m_mode = 3;
        end
      end
      default: begin
        if (i.res) begin m_mode = 0; m_pend = 0; end
      end
    endcase
  endtask

  function automatic out_t dut_out();
    out_t o;
    o.pc      = bus.pc_en;
    o.ifid    = bus.if_id_en;
    o.idex    = bus.id_ex_en;
    o.exmem   = bus.ex_mem_en;
    o.memwb   = bus.mem_wb_en;
    o.ifid_fl = bus.if_id_flush;
    o.idex_fl = bus.id_ex_flush;
    o.bub     = bus.mem_wb_bubble;
    o.halted  = bus.halted;
    o.st      = bus.state;
    return o;
  endfunction

  task automatic drive(input in_t i);
    bus.ld_use_stall = i.ld;
    bus.br_taken     = i.br;
    bus.dmem_req     = i.req;
    bus.dmem_ack     = i.ack;
    bus.halt_req     = i.hreq;
    bus.resume       = i.res;
    bus.wb_valid     = i.wbv;
    bus.cnt_clr      = i.clr;
  endtask

  task automatic check_out(input string name, input out_t got, input out_t want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: outputs got %b expected %b (pc,ifid,idex,exmem,memwb,iffl,idfl,bub,halted,state)",
               name, got, want);
    end
  endtask

  task automatic check_val(input string name, input int got, input int want);
    vectors++;
    if (got != want) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", name, got, want);
    end
  endtask

  task automatic check_cnt(input string name);
    vectors++;
    if (int'(bus.stall_cnt) != m_stall || int'(bus.retire_cnt) != m_retire) begin
      miscompares++;
      $display("FAIL %s counters: got stall=%0d retire=%0d expected stall=%0d retire=%0d",
               name, bus.stall_cnt, bus.retire_cnt, m_stall, m_retire);
    end
  endtask

  // One clock: drive, check on the falling edge, advance model on the rising edge
  task automatic apply(input in_t i, input bit use_exp, input out_t exp, input string name);
    out_t want;
    drive(i);
    want = use_exp ? exp : m_out(i);
    @(negedge clk);
    last = dut_out();
    check_out(name, last, want);
    check_cnt(name);
    @(posedge clk);
    m_step(i);
    #1;
  endtask

  vec_t tbl[$];

  task automatic add_vec(input in_t i, input out_t o, input string name);
    vec_t v;
    v.i = i; v.o = o; v.name = name;
    tbl.push_back(v);
  endtask

  initial begin
    int n;
    int nst;
    bit seen;
    in_t ri;

    vectors = 0; miscompares = 0;
    m_reset();
    drive(I_0);
    rst_n = 1'b0;

    add_vec(I_0,       with_st(O_RUN,  2'b00), "run_normal");
    add_vec(I_LD,      with_st(O_LDU,  2'b00), "load_use");
    add_vec(I_BRLD,    with_st(O_BR,   2'b00), "branch_over_lduse");
    add_vec(I_REQ,     with_st(O_MW,   2'b00), "mwait_from_run");
    add_vec(I_REQBR,   with_st(O_MW,   2'b01), "mwait_ignores_branch");
    add_vec(I_REQACKL, with_st(O_LDU,  2'b01), "mwait_ack_lduse");
    add_vec(I_HREQ,    with_st(O_RUN,  2'b00), "halt_req_cycle");
    add_vec(I_0,       with_st(O_DRN,  2'b10), "drain_1");
    add_vec(I_LD,      with_st(O_LDU,  2'b10), "drain_lduse_hold");
    add_vec(I_BR,      with_st(O_DBR,  2'b10), "drain_branch");
    add_vec(I_REQ,     with_st(O_MW,   2'b10), "drain_mwait");
    add_vec(I_0,       with_st(O_DRN,  2'b10), "drain_3");
    add_vec(I_0,       with_st(O_DRN,  2'b10), "drain_4");
    add_vec(I_BRLDH,   with_st(O_HALT, 2'b11), "halt_ignores");
    add_vec(I_HRES,    with_st(O_HALT, 2'b11), "halt_resume_wins");
    add_vec(I_0,       with_st(O_RUN,  2'b00), "run_after_resume");

    #2;
    check_out("reset_outputs", dut_out(), with_st(O_RST, 2'b00));
    check_val("reset_counters", int'({bus.stall_cnt, bus.retire_cnt}), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    foreach (tbl[k]) apply(tbl[k].i, 1'b1, tbl[k].o, tbl[k].name);

    // Retire counting
    apply(I_CLR, 1'b0, '0, "clr_retire");
    for (int k = 0; k < 10; k++) apply(I_WB, 1'b0, '0, "retire");
    check_val("retire_cnt_10", int'(bus.retire_cnt), 10);

    // Memory wait held three cycles, acked on the fourth
    apply(I_CLR, 1'b0, '0, "clr_mw");
    for (int k = 0; k < 4; k++)
      apply((k == 3) ? I_REQACK : I_REQ, 1'b1,
            (k == 3) ? with_st(O_RUN, 2'b01) : with_st(O_MW, (k == 0) ? 2'b00 : 2'b01),
            "mw_seq");
    apply(I_0, 1'b1, with_st(O_RUN, 2'b00), "mw_back_run");
    check_val("mw_stall_cnt", int'(bus.stall_cnt), 3);

    // Halt pulse: DRAIN_CYC drain cycles then HALT, then resume
    apply(I_HREQ, 1'b0, '0, "halt_pulse");
    n = 0; seen = 0;
    for (int k = 0; k < 12 && !seen; k++) begin
      apply(I_0, 1'b0, '0, "drain_seq");
      if (last.halted) seen = 1;
      else if (last.st == 2'b10 && !last.pc && last.ifid_fl) n++;
    end
    check_val("drain_len", n, DRAIN_CYC);
    check_val("halt_reached", int'(seen), 1);
    apply(I_RES, 1'b1, with_st(O_HALT, 2'b11), "resume_cycle");
    apply(I_0,   1'b1, with_st(O_RUN,  2'b00), "resume_run");

    // Same with a two-cycle memory wait inside DRAIN
    apply(I_HREQ, 1'b0, '0, "halt_pulse2");
    nst = 0; seen = 0;
    for (int k = 0; k < 12 && !seen; k++) begin
      apply((k == 1 || k == 2) ? I_REQ : I_0, 1'b0, '0, "drain_mw_seq");
      if (last.halted) seen = 1;
      else if (last.st == 2'b10) nst++;
    end
    check_val("drain_mw_len", nst, DRAIN_CYC + 2);
    check_val("halt_reached2", int'(seen), 1);
    apply(I_RES, 1'b0, '0, "resume2");

    // Saturation and clear-over-increment
    apply(I_CLR, 1'b0, '0, "clr_sat");
    for (int k = 0; k < 20; k++) apply(I_LD, 1'b0, '0, "sat_ld");
    check_val("stall_saturated", int'(bus.stall_cnt), CMAX);
    apply(I_CLRLD, 1'b0, '0, "clr_wins");
    check_val("clr_wins_val", int'(bus.stall_cnt), 0);

    // Asynchronous reset in the middle of a memory wait
    apply(I_WB, 1'b0, '0, "pre_rst_wb");
    apply(I_REQ, 1'b0, '0, "enter_mwait");
    drive(I_REQ);
    #2;
    rst_n = 1'b0;
    drive(I_0);
    #1;
    check_out("rst_async", dut_out(), with_st(O_RST, 2'b00));
    check_val("rst_async_cnt", int'({bus.stall_cnt, bus.retire_cnt}), 0);
    m_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    m_step(I_0);
    #1;
    apply(I_0, 1'b1, with_st(O_RUN, 2'b00), "post_rst_run");
    check_val("post_rst_cnt", int'({bus.stall_cnt, bus.retire_cnt}), 0);

    // Random stimulus against the reference model
    for (int k = 0; k < 400; k++) begin
      ri.ld   = ($urandom_range(0, 99) < 25);
      ri.br   = ($urandom_range(0, 99) < 20);
      ri.req  = ($urandom_range(0, 99) < 30);
      ri.ack  = ($urandom_range(0, 99) < 50);
      ri.hreq = ($urandom_range(0, 99) < 6);
      ri.res  = ($urandom_range(0, 99) < 15);
      ri.wbv  = ($urandom_range(0, 99) < 50);
      ri.clr  = ($urandom_range(0, 99) < 3);
      apply(ri, 1'b0, '0, "random");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
